// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states and access-size encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_e;

    // Encoding 2'b11 behaves as a word access.
    function automatic ls_size_e norm_size(input logic [1:0] sz);
        case (sz)
            2'b00:   return LS_BYTE;
            2'b01:   return LS_HALF;
            default: return LS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding request/acknowledge data-memory bus between the LSU and memory.
interface load_store_unit_if;

    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wr_data_o;
    logic [3:0]  dmem_wr_mask_o;
    logic        dmem_ack_in;
    logic [31:0] dmem_rd_data_in;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wr_data_o, dmem_wr_mask_o,
        input  dmem_ack_in, dmem_rd_data_in
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wr_data_o, dmem_wr_mask_o,
        output dmem_ack_in, dmem_rd_data_in
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane handling: store replicate/mask and load lane select/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  ls_size_e    st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wr_data,
    output logic [3:0]  st_mask,
    input  ls_size_e    ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wr_data = st_data;
        st_mask    = 4'b1111;
        case (st_size)
            LS_BYTE: begin
                st_wr_data = {4{st_data[7:0]}};
                st_mask    = 4'b0001 << st_off;
            end
            LS_HALF: begin
                st_wr_data = {2{st_data[15:0]}};
                st_mask    = 4'b0011 << {st_off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

        ld_result = ld_word;
        case (ld_size)
            LS_BYTE: ld_result = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            LS_HALF: ld_result = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time over the dmem bus, with timeout and extended load return.
// Optional MISALIGNED_TRAP_EN: misaligned half/word accesses complete without a bus access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               req_valid_in,
    input  logic               mem_wr_req_in,
    input  logic [1:0]         load_size_in,
    input  logic               load_unsigned_in,
    input  logic [31:0]        addr_in,
    input  logic [31:0]        store_data_in,
    input  logic [4:0]         rd_addr_in,
    output logic               busy_o,
    load_store_unit_if.master  dmem,
    output logic [31:0]        lsu_rd_data_o,
    output logic [4:0]         lsu_rd_addr_o,
    output logic               lsu_wr_en_o,
    output logic               lsu_done_o,
    output logic               lsu_timeout_o,
    output logic               misaligned_o
);

    lsu_state_e   state;
    logic [COUNT_W-1:0] count;
    logic [1:0]   lat_off;
    ls_size_e     lat_size;
    logic         lat_unsigned;
    logic [4:0]   lat_rd;
    logic         lat_we;

    ls_size_e     size_n;
    logic [31:0]  st_wr_data;
    logic [3:0]   st_mask;
    logic [31:0]  ld_result;
    logic         misaligned_req;

    assign size_n = norm_size(load_size_in);

`ifdef MISALIGNED_TRAP_EN
    assign misaligned_req = ((size_n == LS_HALF) && addr_in[0]) ||
                            ((size_n == LS_WORD) && (addr_in[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    lsu_align u_align (
        .st_size     (size_n),
        .st_off      (addr_in[1:0]),
        .st_data     (store_data_in),
        .st_wr_data  (st_wr_data),
        .st_mask     (st_mask),
        .ld_size     (lat_size),
        .ld_off      (lat_off),
        .ld_unsigned (lat_unsigned),
        .ld_word     (dmem.dmem_rd_data_in),
        .ld_result   (ld_result)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            count               <= '0;
            lat_off             <= '0;
            lat_size            <= LS_BYTE;
            lat_unsigned        <= 1'b0;
            lat_rd              <= '0;
            lat_we              <= 1'b0;
            busy_o              <= 1'b0;
            dmem.dmem_req_o     <= 1'b0;
            dmem.dmem_we_o      <= 1'b0;
            dmem.dmem_addr_o    <= '0;
            dmem.dmem_wr_data_o <= '0;
            dmem.dmem_wr_mask_o <= '0;
            lsu_rd_data_o       <= '0;
            lsu_rd_addr_o       <= '0;
            lsu_wr_en_o         <= 1'b0;
            lsu_done_o          <= 1'b0;
            lsu_timeout_o       <= 1'b0;
            misaligned_o        <= 1'b0;
        end else begin
            lsu_wr_en_o   <= 1'b0;
            lsu_done_o    <= 1'b0;
            lsu_timeout_o <= 1'b0;
            misaligned_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        lat_off             <= addr_in[1:0];
                        lat_size            <= size_n;
                        lat_unsigned        <= load_unsigned_in;
                        lat_rd              <= rd_addr_in;
                        lat_we              <= mem_wr_req_in;
                        dmem.dmem_we_o      <= mem_wr_req_in;
                        dmem.dmem_addr_o    <= {addr_in[31:2], 2'b00};
                        dmem.dmem_wr_data_o <= st_wr_data;
                        dmem.dmem_wr_mask_o <= mem_wr_req_in ? st_mask : 4'b0000;
                        count               <= '0;
                        busy_o              <= 1'b1;
                        // A trapped access goes straight to the completion cycle.
                        if (misaligned_req) begin
                            state        <= RESP;
                            lsu_done_o   <= 1'b1;
                            misaligned_o <= 1'b1;
                        end else begin
                            state           <= REQ;
                            dmem.dmem_req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_ack_in) begin
                        state           <= RESP;
                        dmem.dmem_req_o <= 1'b0;
                        lsu_done_o      <= 1'b1;
                        lsu_wr_en_o     <= ~lat_we & (lat_rd != 5'd0);
                        if (!lat_we) begin
                            lsu_rd_data_o <= ld_result;
                            lsu_rd_addr_o <= lat_rd;
                        end
                    end else if (count == COUNT_W'(TIMEOUT_CYCLES)) begin
                        state           <= RESP;
                        dmem.dmem_req_o <= 1'b0;
                        lsu_done_o      <= 1'b1;
                        lsu_timeout_o   <= 1'b1;
                    end else begin
                        count <= count + COUNT_W'(1);
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against an arithmetic reference model.
// Honours MISALIGNED_TRAP_EN when the build defines it.
module tb_load_store_unit;

    localparam int unsigned TO = 4;
`ifdef MISALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in;
    logic        mem_wr_req_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_addr_in;
    logic        busy_o;
    logic [31:0] lsu_rd_data_o;
    logic [4:0]  lsu_rd_addr_o;
    logic        lsu_wr_en_o;
    logic        lsu_done_o;
    logic        lsu_timeout_o;
    logic        misaligned_o;

    load_store_unit_if dmem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO), .COUNT_W(8)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .mem_wr_req_in    (mem_wr_req_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .addr_in          (addr_in),
        .store_data_in    (store_data_in),
        .rd_addr_in       (rd_addr_in),
        .busy_o           (busy_o),
        .dmem             (dmem_bus),
        .lsu_rd_data_o    (lsu_rd_data_o),
        .lsu_rd_addr_o    (lsu_rd_addr_o),
        .lsu_wr_en_o      (lsu_wr_en_o),
        .lsu_done_o       (lsu_done_o),
        .lsu_timeout_o    (lsu_timeout_o),
        .misaligned_o     (misaligned_o)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_data  = '0;
    logic [4:0]  last_rd    = '0;
    bit          last_valid = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(busy_o), 0);
        check({tag, "_req"},     32'(dmem_bus.dmem_req_o), 0);
        check({tag, "_we"},      32'(dmem_bus.dmem_we_o), 0);
        check({tag, "_addr"},    dmem_bus.dmem_addr_o, 0);
        check({tag, "_wdata"},   dmem_bus.dmem_wr_data_o, 0);
        check({tag, "_mask"},    32'(dmem_bus.dmem_wr_mask_o), 0);
        check({tag, "_rdata"},   lsu_rd_data_o, 0);
        check({tag, "_rdaddr"},  32'(lsu_rd_addr_o), 0);
        check({tag, "_wren"},    32'(lsu_wr_en_o), 0);
        check({tag, "_done"},    32'(lsu_done_o), 0);
        check({tag, "_timeout"}, 32'(lsu_timeout_o), 0);
        check({tag, "_misal"},   32'(misaligned_o), 0);
    endtask

    // Reference model: plain arithmetic on byte offsets.
    function automatic int unsigned model_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return TRAP && ((a % model_bytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = model_bytes(sz);
        int unsigned first = (a % 4) / n * n;
        return 4'(((1 << n) - 1) << first);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] w);
        int unsigned n = model_bytes(sz);
        int unsigned first = (a % 4) / n * n;
        logic [31:0] v;
        if (n == 4) return w;
        v = (w >> (8 * first)) % (32'd1 << (8 * n));
        if (!uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic run_txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                           input int ack_delay, input logic [31:0] rword, input bit poke);
        bit          mis   = model_misaligned(sz, addr);
        bit          acked = !mis && ack_delay >= 0 && ack_delay <= int'(TO);
        int          e_req = mis ? 0 : acked ? ack_delay + 1 : int'(TO) + 1;
        logic [31:0] e_rdata = model_load(sz, uns, addr, rword);
        int n_req = 0, n_busy = 0, n_wr = 0, n_done = 0, cyc = 0;
        logic got_to = 1'b0, got_mis = 1'b0, got_wr = 1'b0;
        logic [31:0] got_rdata = '0;
        logic [4:0]  got_rd = '0;

        req_valid_in     = 1'b1;
        mem_wr_req_in    = we;
        load_size_in     = sz;
        load_unsigned_in = uns;
        addr_in          = addr;
        store_data_in    = data;
        rd_addr_in       = rd;
        @(negedge clk_in);
        req_valid_in = poke;
        if (poke) begin
            mem_wr_req_in = 1'b1;
            addr_in       = 32'hFFFF_FFF0;
            store_data_in = $urandom;
            load_size_in  = 2'd2;
        end
        while (n_done == 0 && cyc < 40) begin
            if (busy_o) n_busy++;
            dmem_bus.dmem_ack_in     = 1'b0;
            dmem_bus.dmem_rd_data_in = $urandom;
            if (dmem_bus.dmem_req_o) begin
                n_req++;
                check({tag, "_bus_addr"},  dmem_bus.dmem_addr_o, addr - (addr % 4));
                check({tag, "_bus_we"},    32'(dmem_bus.dmem_we_o), 32'(we));
                check({tag, "_bus_mask"},  32'(dmem_bus.dmem_wr_mask_o), we ? 32'(model_mask(sz, addr)) : 0);
                if (we) check({tag, "_bus_wdata"}, dmem_bus.dmem_wr_data_o, model_wdata(sz, data));
                if (n_req - 1 == ack_delay) begin
                    dmem_bus.dmem_ack_in     = 1'b1;
                    dmem_bus.dmem_rd_data_in = rword;
                end
            end
            if (lsu_wr_en_o) n_wr++;
            if (lsu_done_o) begin
                n_done++;
                got_to    = lsu_timeout_o;
                got_mis   = misaligned_o;
                got_wr    = lsu_wr_en_o;
                got_rdata = lsu_rd_data_o;
                got_rd    = lsu_rd_addr_o;
                req_valid_in = 1'b0;
            end
            cyc++;
            @(negedge clk_in);
        end
        dmem_bus.dmem_ack_in = 1'b0;
        req_valid_in = 1'b0;
        check({tag, "_completed"}, 32'(n_done), 1);
        check({tag, "_req_cycles"}, 32'(n_req), 32'(e_req));
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(e_req + 1));
        check({tag, "_wr_en"}, 32'(got_wr), 32'(acked && !we && rd != 0));
        check({tag, "_wr_pulses"}, 32'(n_wr), 32'(acked && !we && rd != 0));
        check({tag, "_timeout"}, 32'(got_to), 32'(!mis && !acked));
        check({tag, "_misaligned"}, 32'(got_mis), 32'(mis));
        if (acked && !we) begin
            if (rd != 0) begin
                check({tag, "_rd_data"}, got_rdata, e_rdata);
                check({tag, "_rd_addr"}, 32'(got_rd), 32'(rd));
                last_data  = e_rdata;
                last_rd    = rd;
                last_valid = 1'b1;
            end else begin
                last_valid = 1'b0;
            end
        end else if (last_valid) begin
            check({tag, "_rd_data_hold"}, got_rdata, last_data);
            check({tag, "_rd_addr_hold"}, 32'(got_rd), 32'(last_rd));
        end
        check({tag, "_idle_busy"}, 32'(busy_o), 0);
        check({tag, "_idle_req"}, 32'(dmem_bus.dmem_req_o), 0);
        check({tag, "_idle_done"}, 32'(lsu_done_o), 0);
        check({tag, "_idle_wren"}, 32'(lsu_wr_en_o), 0);
    endtask

    initial begin
        rst_in = 1'b1;
        req_valid_in = 1'b0;
        mem_wr_req_in = 1'b0;
        load_size_in = '0;
        load_unsigned_in = 1'b0;
        addr_in = '0;
        store_data_in = '0;
        rd_addr_in = '0;
        dmem_bus.dmem_ack_in = 1'b0;
        dmem_bus.dmem_rd_data_in = '0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        run_txn("st_byte",   1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd0, 0, 32'h0, 1'b0);
        run_txn("ld_sbyte",  1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 5'd5, 0, 32'h0000_8000, 1'b0);
        run_txn("ld_uhalf",  1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 5'd6, 0, 32'hBEEF_0000, 1'b0);
        run_txn("ld_shalf",  1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 5'd7, 0, 32'hBEEF_0000, 1'b0);
        run_txn("st_half",   1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h1234_5678, 5'd0, 1, 32'h0, 1'b0);
        run_txn("st_word",   1'b1, 2'd3, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 5'd0, 2, 32'h0, 1'b0);
        run_txn("ack_late3", 1'b0, 2'd2, 1'b0, 32'h0000_2100, 32'h0, 5'd9, 3, 32'h1357_9BDF, 1'b1);
        run_txn("ack_edge",  1'b0, 2'd0, 1'b1, 32'h0000_2103, 32'h0, 5'd10, int'(TO), 32'hF100_0000, 1'b0);
        run_txn("timeout",   1'b0, 2'd2, 1'b0, 32'h0000_2200, 32'h0, 5'd11, -1, 32'h0, 1'b0);
        run_txn("ld_rd0",    1'b0, 2'd2, 1'b0, 32'h0000_2300, 32'h0, 5'd0, 0, 32'h0BAD_F00D, 1'b0);
        run_txn("ld_w_3002", 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 5'd12, 0, 32'h89AB_CDEF, 1'b0);
        run_txn("ld_h_odd",  1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h0, 5'd13, 0, 32'h0000_8001, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_txn("rand", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                    5'($urandom_range(1, 31)), int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom));
        end

        // Reset while a load waits in REQ, then a late ack must be ignored.
        req_valid_in = 1'b1;
        mem_wr_req_in = 1'b0;
        load_size_in = 2'd2;
        addr_in = 32'h0000_4000;
        rd_addr_in = 5'd3;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        @(negedge clk_in);
        check("mid_req_before_rst", 32'(dmem_bus.dmem_req_o), 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_all_zero("mid_rst");
        rst_in = 1'b0;
        dmem_bus.dmem_ack_in = 1'b1;
        dmem_bus.dmem_rd_data_in = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk_in);
            check("late_ack_req", 32'(dmem_bus.dmem_req_o), 0);
            check("late_ack_done", 32'(lsu_done_o), 0);
            check("late_ack_wren", 32'(lsu_wr_en_o), 0);
            check("late_ack_busy", 32'(busy_o), 0);
        end
        dmem_bus.dmem_ack_in = 1'b0;
        last_data = '0;
        last_rd = '0;
        last_valid = 1'b1;
        run_txn("post_rst_ld", 1'b0, 2'd0, 1'b0, 32'h0000_4002, 32'h0, 5'd4, 1, 32'h007F_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
